// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, immediate-format enum and the ID/EX register layout
// shared by the decode stage and its immediate generator.
package riscv_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef enum logic {
    ID_EMPTY = 1'b0,
    ID_FULL  = 1'b1
  } id_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_load;
    logic        illegal;
  } id_ex_t;

  function automatic logic is_rv32i_opcode(input logic [6:0] opcode);
    case (opcode)
      OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
      LUI, AUIPC, SYSTEM, MISC_MEM: is_rv32i_opcode = 1'b1;
      default:                      is_rv32i_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: classifies the instruction format from its opcode and builds the
// sign-extended RV32I immediate; R-type and unknown opcodes yield zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  imm_type,
  output logic [31:0] imm
);

  imm_type_e type_s;

  always_comb begin
    case (instr[6:0])
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: type_s = IMM_I;
      STORE:                                type_s = IMM_S;
      BRANCH:                               type_s = IMM_B;
      LUI, AUIPC:                           type_s = IMM_U;
      JAL:                                  type_s = IMM_J;
      default:                              type_s = IMM_NONE;
    endcase
  end

  // Every format takes its sign from instr[31].
  always_comb begin
    case (type_s)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

  assign imm_type = type_s;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with load-use / writeback hazard detection and the ID/EX register.
// Build option DECODE_WB_BYPASS_EN forwards the writeback port into the operands instead of stalling.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic            id_is_load,
  output logic            id_illegal
);

  logic [6:0]      opcode_s;
  logic [4:0]      rs1_s, rs2_s;
  logic            use_rs1_s, use_rs2_s, live_rs1_s, live_rs2_s;
  logic            load_hazard_s, wb_hit_rs1_s, wb_hit_rs2_s, hazard_s;
  logic            load_en_s, ready_s, transfer_s, no_rd_s, illegal_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s;
  logic [2:0]      imm_type_s;
  logic [31:0]     imm_s;
  id_state_e       state_r, state_nxt_s;
  id_ex_t          id_ex_r, id_ex_nxt_s;

  assign opcode_s = if_instr[6:0];
  assign rs1_s    = if_instr[19:15];
  assign rs2_s    = if_instr[24:20];
  assign rf_rs1   = rs1_s;
  assign rf_rs2   = rs2_s;

  imm_gen u_imm_gen (
    .instr    (if_instr),
    .imm_type (imm_type_s),
    .imm      (imm_s)
  );

  // Which source fields the opcode actually reads; unused fields never stall.
  always_comb begin
    use_rs1_s = 1'b1;
    use_rs2_s = 1'b0;
    case (opcode_s)
      LUI, AUIPC, JAL:   use_rs1_s = 1'b0;
      OP, STORE, BRANCH: use_rs2_s = 1'b1;
      default: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b0;
      end
    endcase
  end

  assign live_rs1_s    = use_rs1_s && (rs1_s != 5'd0);
  assign live_rs2_s    = use_rs2_s && (rs2_s != 5'd0);
  assign load_hazard_s = (state_r == ID_FULL) && id_ex_r.is_load && (id_ex_r.rd != 5'd0) &&
                         ((live_rs1_s && (rs1_s == id_ex_r.rd)) || (live_rs2_s && (rs2_s == id_ex_r.rd)));
  assign wb_hit_rs1_s  = wb_we && (wb_rd != 5'd0) && live_rs1_s && (rs1_s == wb_rd);
  assign wb_hit_rs2_s  = wb_we && (wb_rd != 5'd0) && live_rs2_s && (rs2_s == wb_rd);

`ifdef DECODE_WB_BYPASS_EN
  assign hazard_s  = load_hazard_s;
  assign rs1_val_s = wb_hit_rs1_s ? wb_data : rf_rs1_data;
  assign rs2_val_s = wb_hit_rs2_s ? wb_data : rf_rs2_data;
`else
  // The register file returns stale data on the write cycle, so wait for it to land.
  logic [XLEN-1:0] wb_data_unused_s;
  assign wb_data_unused_s = wb_data;
  assign hazard_s  = load_hazard_s || wb_hit_rs1_s || wb_hit_rs2_s;
  assign rs1_val_s = rf_rs1_data;
  assign rs2_val_s = rf_rs2_data;
`endif

  assign illegal_s  = !is_rv32i_opcode(opcode_s);
  assign no_rd_s    = illegal_s || (imm_type_e'(imm_type_s) == IMM_S) || (imm_type_e'(imm_type_s) == IMM_B);
  assign transfer_s = if_valid && ready_s;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ID_EMPTY;
    else     state_r <= state_nxt_s;
  end

  // Next occupancy: flush beats a transfer, which beats a drain into EX.
  always_comb begin
    state_nxt_s = state_r;
    if (flush)           state_nxt_s = ID_EMPTY;
    else if (transfer_s) state_nxt_s = ID_FULL;
    else if (ex_ready)   state_nxt_s = ID_EMPTY;
    else                 state_nxt_s = state_r;
  end

  // Handshake outputs derived from occupancy and hazards.
  always_comb begin
    load_en_s = (state_r == ID_EMPTY) || ex_ready;
    ready_s   = load_en_s && !hazard_s && !flush;
  end

  always_comb begin
    id_ex_nxt_s         = '0;
    id_ex_nxt_s.pc      = if_pc;
    id_ex_nxt_s.rs1_val = rs1_val_s;
    id_ex_nxt_s.rs2_val = rs2_val_s;
    id_ex_nxt_s.imm     = imm_s;
    id_ex_nxt_s.rd      = no_rd_s ? 5'd0 : if_instr[11:7];
    id_ex_nxt_s.opcode  = opcode_s;
    id_ex_nxt_s.funct3  = if_instr[14:12];
    id_ex_nxt_s.funct7  = if_instr[31:25];
    id_ex_nxt_s.is_load = (opcode_s == LOAD);
    id_ex_nxt_s.illegal = illegal_s;
  end

  // ID/EX payload: loaded only on an accepted transfer, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             id_ex_r <= '{pc: RESET_PC, default: '0};
    else if (transfer_s) id_ex_r <= id_ex_nxt_s;
    else                 id_ex_r <= id_ex_r;
  end

  assign if_ready   = ready_s;
  assign id_valid   = (state_r == ID_FULL);
  assign id_pc      = id_ex_r.pc;
  assign id_rs1_val = id_ex_r.rs1_val;
  assign id_rs2_val = id_ex_r.rs2_val;
  assign id_imm     = id_ex_r.imm;
  assign id_rd      = id_ex_r.rd;
  assign id_opcode  = id_ex_r.opcode;
  assign id_funct3  = id_ex_r.funct3;
  assign id_funct7  = id_ex_r.funct7;
  assign id_is_load = id_ex_r.is_load;
  assign id_illegal = id_ex_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic checked against a
// cycle-level reference model of the decode stage.
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam logic [6:0] T_OP = 7'h33, T_OP_IMM = 7'h13, T_LOAD = 7'h03, T_STORE = 7'h23;
  localparam logic [6:0] T_BRANCH = 7'h63, T_JAL = 7'h6F, T_JALR = 7'h67, T_LUI = 7'h37;
  localparam logic [6:0] T_AUIPC = 7'h17, T_SYSTEM = 7'h73, T_FENCE = 7'h0F;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_load;
    logic        illegal;
  } tb_id_t;

  logic clk = 1'b0;
  logic rst, if_valid, if_ready, flush, wb_we, ex_ready, id_valid, id_is_load, id_illegal;
  logic [31:0] if_instr, if_pc, rf_rs1_data, rf_rs2_data, wb_data;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  rf_rs1, rf_rs2, wb_rd, id_rd;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;

  int n_tests = 0;
  int n_fail  = 0;
  bit     m_valid;
  tb_id_t m_f;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_rd(id_rd),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_is_load(id_is_load), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == T_LUI || op == T_AUIPC || op == T_JAL);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == T_OP || op == T_STORE || op == T_BRANCH);
  endfunction

  function automatic bit ref_ready();
    bit stall = 1'b0;
    logic [6:0] op = if_instr[6:0];
    logic [4:0] s1 = if_instr[19:15];
    logic [4:0] s2 = if_instr[24:20];
    if (m_valid && m_f.is_load && m_f.rd != 5'd0 &&
        ((reads_rs1(op) && s1 == m_f.rd) || (reads_rs2(op) && s2 == m_f.rd))) stall = 1'b1;
    if (!BYPASS && wb_we && wb_rd != 5'd0 &&
        ((reads_rs1(op) && s1 == wb_rd) || (reads_rs2(op) && s2 == wb_rd))) stall = 1'b1;
    return (!m_valid || ex_ready) && !stall && !flush;
  endfunction

  function automatic tb_id_t ref_decode();
    tb_id_t f = '0;
    int s = $signed(if_instr);
    logic [6:0] op = if_instr[6:0];
    f.pc = if_pc;  f.opcode = op;  f.funct3 = if_instr[14:12];  f.funct7 = if_instr[31:25];
    f.is_load = (op == T_LOAD);
    f.rd = if_instr[11:7];
    case (op)
      T_OP: f.imm = 32'd0;
      T_OP_IMM, T_LOAD, T_JALR, T_SYSTEM, T_FENCE: f.imm = 32'(s >>> 20);
      T_STORE: begin
        f.imm = 32'((s >>> 25) * 32 + int'(if_instr[11:7]));
        f.rd  = 5'd0;
      end
      T_BRANCH: begin
        f.imm = 32'((s >>> 31) * 4096 + int'(if_instr[7]) * 2048 + int'(if_instr[30:25]) * 32
                    + int'(if_instr[11:8]) * 2);
        f.rd  = 5'd0;
      end
      T_LUI, T_AUIPC: f.imm = if_instr & 32'hFFFF_F000;
      T_JAL: f.imm = 32'((s >>> 31) * 1048576 + int'(if_instr[19:12]) * 4096
                         + int'(if_instr[20]) * 2048 + int'(if_instr[30:21]) * 2);
      default: begin
        f.illegal = 1'b1;
        f.imm     = 32'd0;
        f.rd      = 5'd0;
      end
    endcase
    f.rs1 = (BYPASS && reads_rs1(op) && wb_we && wb_rd != 5'd0 && wb_rd == if_instr[19:15]) ? wb_data : rf_rs1_data;
    f.rs2 = (BYPASS && reads_rs2(op) && wb_we && wb_rd != 5'd0 && wb_rd == if_instr[24:20]) ? wb_data : rf_rs2_data;
    return f;
  endfunction

  // Advance one clock and update the reference model with the pre-edge inputs.
  task automatic cycle();
    bit rdy = ref_ready();
    tb_id_t nf = ref_decode();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;  m_f = '0;  m_f.pc = RST_PC;
    end else if (flush) m_valid = 1'b0;
    else if (if_valid && rdy) begin
      m_valid = 1'b1;  m_f = nf;
    end else if (ex_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic exr, input logic fl);
    if_valid = v;  if_instr = instr;  if_pc = pc;  ex_ready = exr;  flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;  wb_we = 1'b0;  wb_rd = 5'd0;  wb_data = 32'd0;
    rf_rs1_data = 32'd0;  rf_rs2_data = 32'd0;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    m_valid = 1'b0;  m_f = '0;  m_f.pc = RST_PC;
    #2;
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_tests++; if (id_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", id_pc, RST_PC); end
    n_tests++;
    if ({id_rs1_val, id_rs2_val, id_imm, id_rd, id_opcode, id_funct3, id_funct7, id_is_load, id_illegal} !== '0) begin
      n_fail++; $display("FAIL reset_fields: got imm %h rd %0d op %h", id_imm, id_rd, id_opcode);
    end
    drive(1'b1, 32'h0050_0093, 32'h0000_0040, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_transfer: got %b want 0", id_valid); end
    rst = 1'b0;  if_valid = 1'b0;
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", if_ready); end
  endtask

  task automatic test_addi_stream();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0050_0093, 32'h0000_0100 + 32'(i * 4), 1'b1, 1'b0);
      #1;
      n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready[%0d]: got %b want 1", i, if_ready); end
      cycle();
      n_tests++;
      if ({id_valid, id_imm, id_rd, id_pc} !== {1'b1, 32'd5, 5'd1, 32'h0000_0100 + 32'(i * 4)}) begin
        n_fail++; $display("FAIL addi_capture[%0d]: got v%b imm %h rd %0d pc %h", i, id_valid, id_imm, id_rd, id_pc);
      end
    end
  endtask

  task automatic test_load_use();
    rf_rs1_data = 32'h1111_0005;  rf_rs2_data = 32'h2222_0001;
    drive(1'b1, 32'h0001_2283, 32'h0000_0200, 1'b1, 1'b0);
    cycle();
    n_tests++; if (id_is_load !== 1'b1) begin n_fail++; $display("FAIL lw_is_load: got %b want 1", id_is_load); end
    drive(1'b1, 32'h0012_8333, 32'h0000_0204, 1'b1, 1'b0);
    #1;
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_ready: got %b want 0", if_ready); end
    cycle();
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: got %b want 0", id_valid); end
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release: got %b want 1", if_ready); end
    cycle();
    n_tests++;
    if ({id_valid, id_rd, id_opcode, id_pc, id_rs1_val} !== {1'b1, 5'd6, 7'h33, 32'h0000_0204, 32'h1111_0005}) begin
      n_fail++; $display("FAIL load_use_capture: got v%b rd %0d op %h pc %h rs1 %h", id_valid, id_rd, id_opcode, id_pc, id_rs1_val);
    end
    drive(1'b1, 32'h0001_2283, 32'h0000_0208, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 32'h0010_0333, 32'h0000_020C, 1'b1, 1'b0);
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall_ready: got %b want 1", if_ready); end
    cycle();
    n_tests++;
    if ({id_valid, id_pc} !== {1'b1, 32'h0000_020C}) begin
      n_fail++; $display("FAIL x0_no_stall_capture: got v%b pc %h", id_valid, id_pc);
    end
  endtask

  task automatic test_wb_write();
    wb_we = 1'b1;  wb_rd = 5'd3;  wb_data = 32'hDEAD_BEEF;  rf_rs1_data = 32'd0;
    drive(1'b1, 32'h0001_8233, 32'h0000_0300, 1'b1, 1'b0);
    #1;
`ifdef DECODE_WB_BYPASS_EN
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL wb_bypass_ready: got %b want 1", if_ready); end
    cycle();
    n_tests++;
    if ({id_valid, id_rs1_val} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL wb_bypass_value: got v%b rs1 %h want DEADBEEF", id_valid, id_rs1_val);
    end
`else
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL wb_stall_ready: got %b want 0", if_ready); end
    cycle();
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL wb_stall_bubble: got %b want 0", id_valid); end
    wb_we = 1'b0;  rf_rs1_data = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL wb_stall_release: got %b want 1", if_ready); end
    cycle();
    n_tests++;
    if ({id_valid, id_rs1_val} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL wb_stall_value: got v%b rs1 %h want DEADBEEF", id_valid, id_rs1_val);
    end
`endif
    wb_we = 1'b0;
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h0050_0093, 32'h0000_0400, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 32'h0010_0333, 32'h0000_0404, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rf_rs1_data = $urandom;
      #1;
      n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, if_ready); end
      cycle();
      n_tests++;
      if ({id_valid, id_pc, id_imm, id_rd, id_opcode} !== {1'b1, 32'h0000_0400, 32'd5, 5'd1, 7'h13}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v%b pc %h imm %h rd %0d", i, id_valid, id_pc, id_imm, id_rd);
      end
    end
    ex_ready = 1'b1;
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", if_ready); end
    cycle();
    n_tests++;
    if ({id_valid, id_pc, id_rd} !== {1'b1, 32'h0000_0404, 5'd6}) begin
      n_fail++; $display("FAIL bp_release_capture: got v%b pc %h rd %0d", id_valid, id_pc, id_rd);
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 32'h0001_2283, 32'h0000_0500, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 32'h0012_8333, 32'h0000_0504, 1'b1, 1'b1);
    #1;
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", if_ready); end
    cycle();
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", id_valid); end
    drive(1'b0, 32'h0012_8333, 32'h0000_0504, 1'b1, 1'b0);
    #1;
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_recover_ready: got %b want 1", if_ready); end
    cycle();
    n_tests++;
    if ({id_valid, id_pc} !== {1'b0, 32'h0000_0500}) begin
      n_fail++; $display("FAIL flush_not_captured: got v%b pc %h", id_valid, id_pc);
    end
  endtask

  task automatic test_decode_misc();
    drive(1'b1, 32'h00A2_8F7F, 32'h0000_0600, 1'b1, 1'b0);
    cycle();
    n_tests++;
    if ({id_valid, id_illegal, id_rd} !== {1'b1, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL illegal_opcode: got v%b ill %b rd %0d", id_valid, id_illegal, id_rd);
    end
    drive(1'b1, 32'hFE00_0EE3, 32'h0000_0604, 1'b1, 1'b0);
    cycle();
    n_tests++;
    if ({id_imm, id_rd, id_illegal} !== {32'hFFFF_FFFC, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL beq_imm: got imm %h rd %0d ill %b want FFFFFFFC 0 0", id_imm, id_rd, id_illegal);
    end
  endtask

  task automatic test_random();
    logic [6:0] pool [13] = '{T_OP, T_OP_IMM, T_LOAD, T_LOAD, T_STORE, T_BRANCH, T_JAL,
                             T_JALR, T_LUI, T_AUIPC, T_SYSTEM, T_FENCE, 7'h7F};
    logic [31:0] instr_v;
    bit exp_rdy;
    for (int c = 0; c < 600; c++) begin
      instr_v         = $urandom;
      instr_v[6:0]    = pool[$urandom_range(0, 12)];
      instr_v[11:7]   = 5'($urandom_range(0, 3));
      instr_v[19:15]  = 5'($urandom_range(0, 3));
      instr_v[24:20]  = 5'($urandom_range(0, 3));
      drive(($urandom_range(0, 4) != 0), instr_v, $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
      rf_rs1_data = $urandom;  rf_rs2_data = $urandom;  wb_data = $urandom;
      wb_we = $urandom_range(0, 1);  wb_rd = 5'($urandom_range(0, 3));
      #1;
      exp_rdy = ref_ready();
      n_tests++;
      if ({rf_rs1, rf_rs2} !== {instr_v[19:15], instr_v[24:20]}) begin
        n_fail++; $display("FAIL rand_rf_addr[%0d]: got %0d/%0d want %0d/%0d", c, rf_rs1, rf_rs2, instr_v[19:15], instr_v[24:20]);
      end
      n_tests++; if (if_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, if_ready, exp_rdy); end
      cycle();
      n_tests++; if (id_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", c, id_valid, m_valid); end
      if (m_valid) begin
        n_tests++;
        if ({id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd, id_opcode, id_funct3, id_funct7, id_is_load, id_illegal} !== m_f) begin
          n_fail++; $display("FAIL rand_fields[%0d]: got pc %h imm %h rd %0d rs1 %h rs2 %h want pc %h imm %h rd %0d rs1 %h rs2 %h",
                             c, id_pc, id_imm, id_rd, id_rs1_val, id_rs2_val, m_f.pc, m_f.imm, m_f.rd, m_f.rs1, m_f.rs2);
        end
      end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    wb_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi_stream();
    test_load_use();
    test_wb_write();
    test_backpressure();
    test_flush_stall();
    test_decode_misc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I pipeline. Accepts one fetched instruction per cycle from IF over a valid/ready handshake and drives the register file read addresses combinationally. It detects load-use and writeback hazards, generates the immediate, and captures everything into the ID/EX pipeline register. The register file sits beside it: decode supplies its rs1/rs2 addresses, and the writeback stage drives its write port.

## Interface

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, reset value of id_pc.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF holds a valid instruction.
- if_ready  out  1  decode accepts the instruction this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  32  instruction PC.
- flush  in  1  redirect from EX; kills the ID/EX contents and the incoming instruction.
- rf_rs1, rf_rs2  out  5  register file read addresses, equal to if_instr[19:15] and if_instr[24:20].
- rf_rs1_data, rf_rs2_data  in  32  combinational read data from the register file.
- wb_we  in  1  writeback write enable, the same signal that drives the register file.
- wb_rd  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- ex_ready  in  1  EX accepts the ID/EX contents this cycle.
- id_valid  out  1  ID/EX register holds a valid instruction.
- id_pc, id_rs1_val, id_rs2_val, id_imm  out  32  captured PC, source operands and sign-extended immediate.
- id_rd  out  5  destination register; forced to 0 when the instruction has no destination (S, B).
- id_opcode  out  7  captured opcode.
- id_funct3  out  3  captured funct3.
- id_funct7  out  7  captured funct7.
- id_is_load  out  1  opcode is LOAD.
- id_illegal  out  1  opcode is not in the RV32I base set.

## Operation

- Occupancy FSM:
  - EMPTY state: id_valid is 0.
  - FULL state: id_valid is 1.
  - load_en = !id_valid || ex_ready.
- Source-use rules:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by OP, STORE and BRANCH.
  - A source equal to x0 never causes a hazard.
- Load-use hazard: id_valid && id_is_load && id_rd != 0 && id_rd matches a used source.
- if_ready = load_en && !hazard && !flush.
- Register update:
  - Transfer (if_valid && if_ready): capture all id_* outputs and go to FULL.
  - Otherwise, if ex_ready: clear id_valid (bubble), go to EMPTY.
  - During a hazard, EX consumes the load and a bubble is inserted; the dependent instruction is accepted on the following cycle.
- flush has priority over every other condition: id_valid <= 0 and if_ready = 0 in the same cycle.
- Immediates (I, S, B, U, J) are generated per RV32I and sign-extended from instr[31]. R-type instructions produce id_imm = 0.
- Illegal opcodes are not trapped here. They pass through with id_illegal = 1 and id_rd = 0.

## Timing

- Reset (asynchronous) values:
  - id_valid = 0.
  - id_pc = RESET_PC.
  - All other id_* outputs = 0.
  - if_ready is 1 in the first cycle after reset release.
- Latency: one cycle from the IF transfer to id_valid.
- Throughput: one instruction per cycle when there is no stall.
- rf_rs1/rf_rs2 are combinational from if_instr. Operand data is sampled on the transfer edge.
- Back-pressure: when ex_ready = 0 and id_valid = 1, all id_* outputs hold stable and if_ready = 0.
- A flush asserted mid-stall clears the pending bubble and the hazard. if_ready returns the next cycle.
- Reset asserted mid-transfer discards that transfer.

## Configuration

- DECODE_WB_BYPASS_EN defined:
  - A used source equal to wb_rd, with wb_we = 1 and wb_rd != 0, takes wb_data instead of the register file data.
  - This covers the same-cycle write, which the register file returns stale.
- DECODE_WB_BYPASS_EN undefined:
  - wb_data is ignored.
  - The same match is treated as an additional hazard, so if_ready = 0 for that cycle and the instruction is captured after the write lands.

## Structure

- Shared package riscv_pkg contains:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM);
  - an imm_type_e enum;
  - an id_ex_t packed struct holding the ID/EX register fields.
- Sub-module imm_gen: combinational opcode/instruction to {imm_type, imm}.
- Hazard detection and the bypass mux stay in decode_stage.

## Test plan

- Reset, then stream ADDI x1,x0,5 (0x00500093) with ex_ready = 1 -> next cycle: id_valid = 1, id_imm = 5, id_rd = 1, id_pc = if_pc; if_ready stays 1 every cycle.
- LW x5,0(x2) followed by ADD x6,x5,x1 -> one bubble cycle with id_valid = 0 and if_ready = 0; the ADD is captured the next cycle. The same test with ADD x6,x0,x1 -> no stall.
- With bypass enabled: wb_we = 1, wb_rd = 3, wb_data = 0xDEADBEEF, rf_rs1_data = 0, while decoding ADD x4,x3,x0 -> id_rs1_val = 0xDEADBEEF. With bypass disabled -> one stall cycle, then the register file value.
- Hold ex_ready = 0 for 3 cycles with id_valid = 1 -> all id_* outputs are stable and if_ready = 0; after release the next instruction is captured.
- Assert flush during a load-use stall -> id_valid = 0 the next cycle, if_ready = 1 the cycle after that, and the stalled instruction is not captured.
- Decode opcode 0x7F, and BEQ with imm = -4 -> id_illegal = 1 with id_rd = 0; the BEQ gives id_imm = 0xFFFFFFFC.
